// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the clock frequency monitor.
// Optional duty-cycle measurement is enabled with CLK_MON_DUTY_EN.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    HALTED  = 2'd3
  } clk_mon_state_e;

  localparam int SYNC_MIN = 2;

  // Saturating increment; callers zero-extend their value and ceiling to 32 bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/clk_mon_sync.sv
// Synchronizer chain for the monitored clock plus a rising-edge detector.
module clk_mon_sync
  import clk_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mon_clk,
  output logic synced,
  output logic rise
);

  localparam int N = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;

  logic [N-1:0] sync_q;
  logic         edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[N-2:0], mon_clk};
      edge_q <= sync_q[N-1];
    end
  end

  assign synced = sync_q[N-1];
  assign rise   = synced & ~edge_q;

endmodule

// File: rtl/clk_freq_monitor.sv
// Measures the period of mon_clk in clk cycles, checks it against a window
// and flags a stopped clock. CLK_MON_DUTY_EN adds the high_time output.
module clk_freq_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mon_clk,
  input  logic                 enable,
  input  logic [CNT_W-1:0]     exp_min,
  input  logic [CNT_W-1:0]     exp_max,
  input  logic [CNT_W-1:0]     timeout,
  input  logic                 clr_err,
  output logic [CNT_W-1:0]     period,
  output logic                 period_vld,
  output logic                 freq_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
`ifdef CLK_MON_DUTY_EN
  output logic [CNT_W-1:0]     high_time,
`endif
  output logic                 halted
);

  localparam logic [CNT_W-1:0]     CNT_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  clk_mon_state_e     state;
  logic [CNT_W-1:0]   cnt, cnt_inc;
  logic [ERR_CNT_W-1:0] err_inc;
  logic               synced, rise, tmo, viol;

  clk_mon_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .mon_clk(mon_clk),
    .synced (synced),
    .rise   (rise)
  );

  assign cnt_inc = CNT_W'(sat_inc(32'(cnt), 32'(CNT_MAX)));
  assign err_inc = ERR_CNT_W'(sat_inc(32'(err_cnt), 32'(ERR_MAX)));
  assign tmo     = (timeout != '0) && (cnt >= timeout);
  // Window check runs on the cycle the period is reported, against that period.
  assign viol    = period_vld && ((period < exp_min) || (period > exp_max));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      halted     <= 1'b0;
    end else begin
      period_vld <= 1'b0;
      if (!enable) begin
        state  <= IDLE;
        cnt    <= '0;
        halted <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            state <= ARM;
          end
          ARM: begin
            if (rise) begin
              cnt   <= CNT_W'(1);
              state <= MEASURE;
            end else begin
              cnt <= cnt_inc;
              if (tmo) begin
                state  <= HALTED;
                halted <= 1'b1;
              end
            end
          end
          MEASURE: begin
            if (rise) begin
              period     <= cnt;
              period_vld <= 1'b1;
              cnt        <= CNT_W'(1);
            end else begin
              cnt <= cnt_inc;
              if (tmo) begin
                state  <= HALTED;
                halted <= 1'b1;
              end
            end
          end
          HALTED: begin
            // The interval spanning the stop is discarded.
            if (rise) begin
              halted <= 1'b0;
              cnt    <= CNT_W'(1);
              state  <= MEASURE;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_err <= 1'b0;
      err_cnt  <= '0;
    end else if (viol) begin
      freq_err <= 1'b1;
      err_cnt  <= clr_err ? ERR_CNT_W'(1) : err_inc;
    end else if (clr_err) begin
      freq_err <= 1'b0;
      err_cnt  <= '0;
    end
  end

`ifdef CLK_MON_DUTY_EN
  logic [CNT_W-1:0] hcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt      <= '0;
      high_time <= '0;
    end else if (!enable || state == IDLE) begin
      hcnt <= '0;
    end else if (rise) begin
      if (state == MEASURE) high_time <= hcnt;
      hcnt <= CNT_W'(1);
    end else if (synced) begin
      hcnt <= CNT_W'(sat_inc(32'(hcnt), 32'(CNT_MAX)));
    end
  end
`else
  logic unused_synced;
  assign unused_synced = synced;
`endif

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Scoreboard bench for clk_freq_monitor: a divider model pushes expected
// periods per generated edge; a monitor pops them on period_vld.
module tb_clk_freq_monitor;
  localparam int CNT_W = 16;
  localparam int ERR_W = 8;

  logic clk = 1'b0, rst_n = 1'b0, mon_clk = 1'b0, enable = 1'b0, clr_err = 1'b0;
  logic [CNT_W-1:0] exp_min = 16'd7, exp_max = 16'd9, timeout = 16'd20;
  logic [CNT_W-1:0] period;
  logic             period_vld, freq_err, halted;
  logic [ERR_W-1:0] err_cnt;
`ifdef CLK_MON_DUTY_EN
  logic [CNT_W-1:0] high_time;
`endif

  int n_cmp = 0, n_err = 0;
  int sb[$];
  int vld_seen = 0;
  bit run = 1'b0, ref_needed = 1'b1;
  int div = 8, cur_div = 8, ph = 0, cyc = 0, last_rise = 0;
  bit m_ferr = 1'b0, pend = 1'b0;
  int m_ecnt = 0, pend_p = 0;

  clk_freq_monitor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mon_clk   (mon_clk),
    .enable    (enable),
    .exp_min   (exp_min),
    .exp_max   (exp_max),
    .timeout   (timeout),
    .clr_err   (clr_err),
    .period    (period),
    .period_vld(period_vld),
    .freq_err  (freq_err),
    .err_cnt   (err_cnt),
`ifdef CLK_MON_DUTY_EN
    .high_time (high_time),
`endif
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Divider: mon_clk rises at ph==0; every measured edge pushes its true period.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!run) begin
        mon_clk    = 1'b0;
        ph         = 0;
        ref_needed = 1'b1;
        cur_div    = div;
      end else begin
        if (ph == 0) begin
          mon_clk = 1'b1;
          if (!ref_needed) sb.push_back(cyc - last_rise);
          ref_needed = 1'b0;
          last_rise  = cyc;
        end else if (ph == cur_div / 2) begin
          mon_clk = 1'b0;
        end
        ph = (ph + 1 == cur_div) ? 0 : ph + 1;
        if (ph == 0) cur_div = div;
      end
    end
  end

  // Monitor: pops periods, and keeps a model of freq_err/err_cnt.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        m_ferr = 1'b0; m_ecnt = 0; pend = 1'b0;
      end else begin
        if (pend && (pend_p < int'(exp_min) || pend_p > int'(exp_max))) begin
          m_ferr = 1'b1;
          m_ecnt = clr_err ? 1 : ((m_ecnt >= 255) ? 255 : m_ecnt + 1);
        end else if (clr_err) begin
          m_ferr = 1'b0; m_ecnt = 0;
        end
        pend = 1'b0;
      end
      chk("freq_err_model", 32'(freq_err), 32'(m_ferr));
      chk("err_cnt_model", 32'(err_cnt), 32'(m_ecnt));
      if (rst_n && period_vld) begin
        vld_seen++;
        if (sb.size() == 0) begin
          chk("spurious_vld", 32'(period_vld), 32'd0);
        end else begin
          pend_p = sb.pop_front();
          pend   = 1'b1;
          chk("period", 32'(period), 32'(pend_p));
        end
      end
    end
  end

  task automatic wait_vld(input int n);
    int target = vld_seen + n;
    int b = 0;
    while (vld_seen < target && b < n * 30 + 50) begin
      @(posedge clk); #2;
      b++;
    end
    chk("vld_wait", 32'(vld_seen >= target), 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int b;
    // reset state
    cycles(3);
    chk("rst_period", 32'(period), 0);
    chk("rst_vld", 32'(period_vld), 0);
    chk("rst_freq_err", 32'(freq_err), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_halted", 32'(halted), 0);
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1;
    cycles(1);
    run = 1'b1;

    // clk/8, in window
    wait_vld(5);
    chk("div8_freq_err", 32'(freq_err), 0);
    chk("div8_err_cnt", 32'(err_cnt), 0);
`ifdef CLK_MON_DUTY_EN
    chk("div8_high_time", 32'(high_time), 4);
`endif

    // switch to clk/12: one more 8, then three 12s
    wait_vld(1);
    div = 12;
    wait_vld(4);
    cycles(1);
    chk("div12_freq_err", 32'(freq_err), 1);
    chk("div12_err_cnt", 32'(err_cnt), 3);
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
    chk("clr_freq_err", 32'(freq_err), 0);
    chk("clr_err_cnt", 32'(err_cnt), 0);

    // stop mon_clk
    run = 1'b0;
    div = 8;
    cycles(10);
    chk("stop_not_halted_yet", 32'(halted), 0);
    b = 0;
    while (!halted && b < 40) begin cycles(1); b++; end
    chk("halted", 32'(halted), 1);
    run = 1'b1;
    b = 0;
    while (halted && b < 20) begin cycles(1); b++; end
    chk("restart_halted", 32'(halted), 0);
    wait_vld(2);
    chk("restart_period", 32'(period), 8);

    // inverted window: every period violates, err_cnt saturates
    exp_min = 16'd10; exp_max = 16'd5;
    wait_vld(300);
    cycles(1);
    chk("sat_err_cnt", 32'(err_cnt), 255);
    chk("sat_freq_err", 32'(freq_err), 1);

    // clr_err collides with a violating report
    b = 0;
    do begin @(posedge clk); #1; b++; end while (!period_vld && b < 40);
    chk("collide_vld_seen", 32'(period_vld), 1);
    #1 clr_err = 1'b1;
    @(posedge clk); #2;
    clr_err = 1'b0;
    chk("collide_freq_err", 32'(freq_err), 1);
    chk("collide_err_cnt", 32'(err_cnt), 1);

    // async reset mid-MEASURE
    exp_min = 16'd7; exp_max = 16'd9;
    wait_vld(2);
    cycles(3);
    #1 rst_n = 1'b0;
    run = 1'b0;
    sb.delete();
    #1;
    chk("areset_period", 32'(period), 0);
    chk("areset_vld", 32'(period_vld), 0);
    chk("areset_freq_err", 32'(freq_err), 0);
    chk("areset_err_cnt", 32'(err_cnt), 0);
    chk("areset_halted", 32'(halted), 0);
    cycles(3);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
    run = 1'b1;
    wait_vld(2);
    chk("post_reset_period", 32'(period), 8);

    run = 1'b0;
    cycles(10);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
